// File: rtl/alu_z_writeback.sv
// alu_z_writeback: captures the ALU's 64-bit result into Z on start and
// writes it back over the shared register bus using a request/grant
// handshake. Single-word ops take one beat (to Rz). mul and div take two
// beats, LO first and then HI. done pulses once the write-back completes.
// Optional feature: define ALU_WB_DROP_ERR_EN to build the sticky drop_err
// flag. drop_err records any start that arrives while the block is busy.
module alu_z_writeback #(
  parameter int unsigned wordSize = 32
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    start,
  input  logic [4:0]              opcode,
  input  logic [2*wordSize-1:0]   C,
  output logic                    bus_req,
  input  logic                    bus_grant,
  output logic [wordSize-1:0]     bus_out,
  output logic [1:0]              dest_sel,
  output logic                    wr_en,
  output logic                    busy,
  output logic                    done,
  output logic                    drop_err
);

  localparam int unsigned ZW = 2 * wordSize;

  localparam logic [4:0] OP_MUL = 5'b00011;
  localparam logic [4:0] OP_DIV = 5'b00100;

  localparam logic [1:0] DEST_NONE = 2'b00;
  localparam logic [1:0] DEST_RZ   = 2'b01;
  localparam logic [1:0] DEST_LO   = 2'b10;
  localparam logic [1:0] DEST_HI   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOW  = 2'b01,
    S_HIGH = 2'b10,
    S_DONE = 2'b11
  } state_e;

  state_e          state_q, state_d;
  logic [ZW-1:0]   z_q, z_d;
  logic            two_beat_q, two_beat_d;

  // State, Z register and captured op type; clr has priority
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      z_q        <= '0;
      two_beat_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      z_q        <= z_d;
      two_beat_q <= two_beat_d;
    end
  end

  // Next-state logic and output decode of state, Z and grant
  always_comb begin
    state_d    = state_q;
    z_d        = z_q;
    two_beat_d = two_beat_q;
    bus_req    = 1'b0;
    bus_out    = '0;
    dest_sel   = DEST_NONE;
    wr_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          z_d        = C;
          two_beat_d = (opcode == OP_MUL) || (opcode == OP_DIV);
          state_d    = S_LOW;
        end
      end
      S_LOW: begin
        busy     = 1'b1;
        bus_req  = 1'b1;
        bus_out  = z_q[wordSize-1:0];
        dest_sel = two_beat_q ? DEST_LO : DEST_RZ;
        wr_en    = bus_grant;
        if (bus_grant) begin
          state_d = two_beat_q ? S_HIGH : S_DONE;
        end
      end
      S_HIGH: begin
        busy     = 1'b1;
        bus_req  = 1'b1;
        bus_out  = z_q[ZW-1:wordSize];
        dest_sel = DEST_HI;
        wr_en    = bus_grant;
        if (bus_grant) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef ALU_WB_DROP_ERR_EN
  logic drop_err_q, drop_err_d;

  // A start that lands while busy is lost; remember it until clr
  always_comb begin
    drop_err_d = drop_err_q | (start & busy);
  end

  // Sticky drop flag register
  always_ff @(posedge clk) begin
    if (clr) begin
      drop_err_q <= 1'b0;
    end else begin
      drop_err_q <= drop_err_d;
    end
  end

  assign drop_err = drop_err_q;
`else
  assign drop_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_z_writeback.sv
// Directed bench for alu_z_writeback. A transaction-level model keeps the
// queue of bus beats still owed, plus a pending-done flag, and a negedge
// process compares every output against that model on each cycle.
// Literal checks inside the directed sequences pin the model itself.
module tb_alu_z_writeback;

  localparam int unsigned W = 32;

  logic          clk;
  logic          clr;
  logic          start;
  logic [4:0]    opcode;
  logic [2*W-1:0] C;
  logic          bus_req;
  logic          bus_grant;
  logic [W-1:0]  bus_out;
  logic [1:0]    dest_sel;
  logic          wr_en;
  logic          busy;
  logic          done;
  logic          drop_err;

  int total = 0;
  int bad   = 0;

  alu_z_writeback #(.wordSize(W)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .opcode    (opcode),
    .C         (C),
    .bus_req   (bus_req),
    .bus_grant (bus_grant),
    .bus_out   (bus_out),
    .dest_sel  (dest_sel),
    .wr_en     (wr_en),
    .busy      (busy),
    .done      (done),
    .drop_err  (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef ALU_WB_DROP_ERR_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  // Model: beats still owed to the bus, in order
  typedef struct {
    logic [1:0]   dest;
    logic [W-1:0] data;
  } beat_t;

  beat_t m_q[$];
  bit    m_done_pending = 0;
  bit    m_drop = 0;
  bit    check_on = 0;

  // Compare outputs to the model, then advance the model by the inputs
  // that the next rising edge will sample
  always @(negedge clk) begin
    bit exp_busy;
    bit exp_req;
    logic [W-1:0] exp_out;
    logic [1:0] exp_dest;
    beat_t b;
    exp_req  = (m_q.size() != 0);
    exp_busy = exp_req || m_done_pending;
    exp_out  = exp_req ? m_q[0].data : '0;
    exp_dest = exp_req ? m_q[0].dest : 2'b00;
    if (check_on) begin
      check("m_bus_req",  64'(bus_req),  64'(exp_req));
      check("m_busy",     64'(busy),     64'(exp_busy));
      check("m_done",     64'(done),     64'(m_done_pending));
      check("m_bus_out",  64'(bus_out),  64'(exp_out));
      check("m_dest_sel", 64'(dest_sel), 64'(exp_dest));
      check("m_wr_en",    64'(wr_en),    64'(exp_req && bus_grant));
      check("m_drop_err", 64'(drop_err), 64'(m_drop));
    end
    if (clr) begin
      m_q.delete();
      m_done_pending = 0;
      m_drop = 0;
    end else begin
      if (DROP_EN && start && exp_busy) m_drop = 1;
      if (m_done_pending) begin
        m_done_pending = 0;
      end else if (m_q.size() != 0) begin
        if (bus_grant) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_done_pending = 1;
        end
      end else if (start) begin
        if (opcode == 5'b00011 || opcode == 5'b00100) begin
          b.dest = 2'b10; b.data = C[W-1:0];   m_q.push_back(b);
          b.dest = 2'b11; b.data = C[2*W-1:W]; m_q.push_back(b);
        end else begin
          b.dest = 2'b01; b.data = C[W-1:0];   m_q.push_back(b);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start, then sit in the first cycle after it
  task automatic do_start(input logic [4:0] op, input logic [63:0] c);
    start = 1'b1; opcode = op; C = c;
    tick();
    start = 1'b0;
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; opcode = '0; C = '0; bus_grant = 1'b0;
    tick();
    check_on = 1;
    tick();
    clr = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req",  64'(bus_req), 64'd0);
    check("rst_out",  64'(bus_out), 64'd0);
    check("rst_drop", 64'(drop_err), 64'd0);

    // 1: add, single beat to Rz
    bus_grant = 1'b1;
    do_start(5'b00001, 64'h0000_0000_0000_0007);
    #1;
    check("add_wr",   64'(wr_en), 64'd1);
    check("add_dest", 64'(dest_sel), 64'h1);
    check("add_out",  64'(bus_out), 64'h7);
    tick(); #1;
    check("add_done", 64'(done), 64'd1);
    tick(); #1;
    check("add_idle", 64'(busy), 64'd0);
    check("add_done0", 64'(done), 64'd0);

    // 2: mul, two beats LO then HI
    do_start(5'b00011, 64'h0000_0001_8000_0000);
    #1;
    check("mul_lo_dest", 64'(dest_sel), 64'h2);
    check("mul_lo_out",  64'(bus_out), 64'h8000_0000);
    tick(); #1;
    check("mul_hi_dest", 64'(dest_sel), 64'h3);
    check("mul_hi_out",  64'(bus_out), 64'h1);
    check("mul_hi_wr",   64'(wr_en), 64'd1);
    tick(); #1;
    check("mul_done", 64'(done), 64'd1);
    tick();

    // 3: div with backpressure on the LO beat
    bus_grant = 1'b0;
    do_start(5'b00100, 64'h0000_0003_0000_0005);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_req", 64'(bus_req), 64'd1);
      check("bp_wr",  64'(wr_en), 64'd0);
      check("bp_out", 64'(bus_out), 64'h5);
      check("bp_dest", 64'(dest_sel), 64'h2);
      tick();
    end
    bus_grant = 1'b1;
    #1;
    check("bp_lo_wr", 64'(wr_en), 64'd1);
    tick(); #1;
    check("bp_hi_out", 64'(bus_out), 64'h3);
    check("bp_hi_wr",  64'(wr_en), 64'd1);
    tick(); #1;
    check("bp_done", 64'(done), 64'd1);
    tick();

    // 4: start during LOW is ignored
    bus_grant = 1'b0;
    do_start(5'b00001, 64'h0000_0000_0000_0011);
    do_start(5'b00011, 64'hFFFF_FFFF_FFFF_FFFF);
    #1;
    check("ign_out",  64'(bus_out), 64'h11);
    check("ign_dest", 64'(dest_sel), 64'h1);
    check("ign_drop", 64'(drop_err), 64'(DROP_EN));
    bus_grant = 1'b1;
    tick(); #1;
    check("ign_done", 64'(done), 64'd1);
    // start during DONE is ignored as well
    do_start(5'b00001, 64'h0000_0000_0000_0022);
    #1;
    check("ign2_idle", 64'(busy), 64'd0);
    check("ign2_drop", 64'(drop_err), 64'(DROP_EN));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    check("clr_drop", 64'(drop_err), 64'd0);

    // 5: clr while waiting in HIGH abandons the HI beat
    do_start(5'b00011, 64'h0000_00AA_0000_00BB);
    tick();
    bus_grant = 1'b0;
    #1;
    check("cl_hi_out", 64'(bus_out), 64'hAA);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bus_grant = 1'b1;
    #1;
    check("cl_req",  64'(bus_req), 64'd0);
    check("cl_busy", 64'(busy), 64'd0);
    check("cl_done", 64'(done), 64'd0);
    check("cl_out",  64'(bus_out), 64'd0);
    tick(); #1;
    check("cl_done2", 64'(done), 64'd0);

    // 6: zero opcode, single beat to Rz
    do_start(5'b00000, 64'h0000_0000_0000_00A5);
    #1;
    check("z_dest", 64'(dest_sel), 64'h1);
    check("z_out",  64'(bus_out), 64'hA5);
    tick(); #1;
    check("z_done", 64'(done), 64'd1);

    // Undefined high opcode, also single beat
    tick();
    do_start(5'b11111, 64'h1234_5678_9ABC_DEF0);
    #1;
    check("u_dest", 64'(dest_sel), 64'h1);
    check("u_out",  64'(bus_out), 64'h9ABC_DEF0);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
